// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit up/down counter: configuration handshake,
// run/pause/resume/abort state machine, registered count and one-cycle event pulses.
module counter_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_dir,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             cfg_acc_s;
    logic             at_term_s;

    // Down-counting starts from the limit; up-counting starts from zero.
    function automatic logic [WIDTH-1:0] start_val(input logic [WIDTH-1:0] lim,
                                                   input logic dir);
        logic [WIDTH-1:0] sv;
        if (dir) begin
            sv = lim;
        end else begin
            sv = {WIDTH{1'b0}};
        end
        return sv;
    endfunction

    function automatic logic [WIDTH-1:0] term_val(input logic [WIDTH-1:0] lim,
                                                  input logic dir);
        logic [WIDTH-1:0] tv;
        if (dir) begin
            tv = {WIDTH{1'b0}};
        end else begin
            tv = lim;
        end
        return tv;
    endfunction

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_ARMED) || (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign cfg_acc_s = cfg_valid && cfg_ready;
    assign at_term_s = (count_q == term_val(limit_q, dir_q));

    assign count = count_q;
    assign state = state_q;
    assign done  = done_q;
    assign wrap  = wrap_q;

    // Next-state, count and pulse decode; abort outranks config accept, which outranks state actions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            count_d = {WIDTH{1'b0}};
        end else if (cfg_acc_s) begin
            limit_d = cfg_limit;
            dir_d   = cfg_dir;
            mode_d  = cfg_mode;
            count_d = start_val(cfg_limit, cfg_dir);
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    // Terminal action takes precedence over pause so a held counter never sits at TV.
                    if (at_term_s) begin
                        if (mode_q) begin
                            count_d = start_val(limit_q, dir_q);
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (pause) begin
                        state_d = ST_HOLD;
                    end else if (dir_q) begin
                        count_d = count_q - WIDTH'(1'b1);
                    end else begin
                        count_d = count_q + WIDTH'(1'b1);
                    end
                end
                ST_HOLD: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        count_d = start_val(limit_q, dir_q);
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, count, latched configuration and event pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= {WIDTH{1'b0}};
            limit_q <= {WIDTH{1'b0}};
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed-vector bench for counter_seq_ctrl: a table of per-edge stimulus and expected
// outputs, plus a hand-written asynchronous reset sequence.
module tb_counter_seq_ctrl;

    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_limit;
    logic         cfg_dir;
    logic         cfg_mode;
    logic         start;
    logic         pause;
    logic         abort;
    logic [W-1:0] count;
    logic [2:0]   state;
    logic         busy;
    logic         done;
    logic         wrap;

    int n_vec;
    int n_bad;

    typedef struct {
        string        name;
        logic         cv;
        logic [W-1:0] lim;
        logic         dir;
        logic         mode;
        logic         st;
        logic         pa;
        logic         ab;
        logic [2:0]   e_state;
        logic [W-1:0] e_cnt;
        logic         e_done;
        logic         e_wrap;
    } vec_t;

    vec_t vq[$];

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_limit (cfg_limit),
        .cfg_dir   (cfg_dir),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .state     (state),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string nm, input logic cv, input int lim, input logic dir,
                       input logic mode, input logic st, input logic pa, input logic ab,
                       input int es, input int ec, input logic ed, input logic ew);
        vec_t v;
        v.name = nm; v.cv = cv; v.lim = W'(lim); v.dir = dir; v.mode = mode;
        v.st = st; v.pa = pa; v.ab = ab;
        v.e_state = 3'(es); v.e_cnt = W'(ec); v.e_done = ed; v.e_wrap = ew;
        vq.push_back(v);
    endtask

    // cfg_ready and busy are expected from the state decode: ready in IDLE/ARMED/DONE, busy in RUN/HOLD.
    task automatic check(input string nm, input logic [2:0] es, input logic [W-1:0] ec,
                         input logic ed, input logic ew);
        logic er;
        logic eb;
        er = (es == 3'd0) || (es == 3'd1) || (es == 3'd4);
        eb = (es == 3'd2) || (es == 3'd3);
        n_vec++;
        if (state !== es || count !== ec || cfg_ready !== er || busy !== eb ||
            done !== ed || wrap !== ew) begin
            n_bad++;
            $display("FAIL %s: got state=%0d count=%0d rdy=%0b busy=%0b done=%0b wrap=%0b, want state=%0d count=%0d rdy=%0b busy=%0b done=%0b wrap=%0b",
                     nm, state, count, cfg_ready, busy, done, wrap, es, ec, er, eb, ed, ew);
        end
    endtask

    task automatic drive(input logic cv, input logic [W-1:0] lim, input logic dir,
                         input logic mode, input logic st, input logic pa, input logic ab);
        cfg_valid = cv; cfg_limit = lim; cfg_dir = dir; cfg_mode = mode;
        start = st; pause = pa; abort = ab;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //   name          cv lim d m  st pa ab  state cnt done wrap
        add("up5_cfg",     1, 5, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        add("up5_start",   0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add("up5_run", 0, 0, 0, 0, 0, 0, 0, 2, i, 0, 0);
        add("up5_done",    0, 0, 0, 0, 0, 0, 0,  4, 5, 1, 0);
        add("up5_done2",   0, 0, 0, 0, 0, 0, 0,  4, 5, 0, 0);
        add("dn3_cfg",     1, 3, 1, 1, 0, 0, 0,  1, 3, 0, 0);
        add("dn3_start",   0, 0, 0, 0, 1, 0, 0,  2, 3, 0, 0);
        add("dn3_r2",      0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0);
        add("dn3_r1",      0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("dn3_r0",      0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);
        add("dn3_wrap1",   0, 0, 0, 0, 0, 0, 0,  2, 3, 0, 1);
        add("dn3_r2b",     0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0);
        add("dn3_r1b",     0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("dn3_r0b",     0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);
        add("dn3_wrap2",   0, 0, 0, 0, 0, 0, 0,  2, 3, 0, 1);
        add("dn3_r2c",     0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0);
        add("dn3_abort",   0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);
        add("p7_cfg",      1, 7, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        add("p7_armpause", 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0);
        add("p7_start",    0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0);
        add("p7_r1",       0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("p7_r2",       0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0);
        add("p7_pause",    0, 0, 0, 0, 0, 1, 0,  3, 2, 0, 0);
        add("p7_hold_pa",  0, 0, 0, 0, 0, 1, 0,  3, 2, 0, 0);
        add("p7_hold_cfg", 1, 1, 1, 0, 0, 0, 0,  3, 2, 0, 0);
        add("p7_hold",     0, 0, 0, 0, 0, 0, 0,  3, 2, 0, 0);
        add("p7_resume",   0, 0, 0, 0, 1, 0, 0,  2, 2, 0, 0);
        for (int i = 3; i <= 7; i++) add("p7_run", 0, 0, 0, 0, 0, 0, 0, 2, i, 0, 0);
        add("p7_done",     0, 0, 0, 0, 0, 0, 0,  4, 7, 1, 0);
        add("rerun_start", 0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0);
        add("rerun_r1",    0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("st_pa_both",  0, 0, 0, 0, 1, 1, 0,  3, 1, 0, 0);
        add("rerun_res",   0, 0, 0, 0, 1, 0, 0,  2, 1, 0, 0);
        for (int i = 2; i <= 4; i++) add("rerun_run", 0, 0, 0, 0, 0, 0, 0, 2, i, 0, 0);
        add("abort_at4",   0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);
        add("abort_cfg",   1, 4, 0, 0, 0, 0, 1,  0, 0, 0, 0);
        add("idle_start",  0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
        add("idle_pause",  0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0);
        add("l0_cfg",      1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        add("l0_start",    0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0);
        add("l0_done",     0, 0, 0, 0, 0, 0, 0,  4, 0, 1, 0);
        add("pt_cfg",      1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        add("pt_start",    0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0);
        add("pt_r1",       0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("pt_r2",       0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0);
        add("pt_pause_tv", 0, 0, 0, 0, 0, 1, 0,  4, 2, 1, 0);
        add("pw_cfg",      1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0);
        add("pw_start",    0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0);
        add("pw_r1",       0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("pw_pause_tv", 0, 0, 0, 0, 0, 1, 0,  2, 0, 0, 1);
        add("pw_r1b",      0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        add("pw_abort_tv", 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0);

        reset = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_state", 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].cv, vq[i].lim, vq[i].dir, vq[i].mode, vq[i].st, vq[i].pa, vq[i].ab);
            @(posedge clk);
            #1;
            check(vq[i].name, vq[i].e_state, vq[i].e_cnt, vq[i].e_done, vq[i].e_wrap);
        end

        // Asynchronous reset between edges while running, then start must be ignored until a new config.
        @(negedge clk);
        drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_pre", 3'd2, 3'd2, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_start_ign", 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_recfg", 3'd1, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_restart", 3'd2, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_step_dn", 3'd2, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
